// File: rtl/dispatch_demux8.sv
// One-to-eight dispatch demultiplexer: a 2-entry in-order buffer of
// {sel, data} whose head is presented on exactly one of eight channels.
module dispatch_demux8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int DEPTH = 2;
  localparam int NCH   = 8;

  logic [1:0]       count_reg, count_next;
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;

  logic [2:0]       sel_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic             nonempty;
  logic             push;
  logic             pop;
  logic [2:0]       head_sel;
  logic [WIDTH-1:0] head_data;

  // Every output is decoded from registered state only; out_ready never
  // reaches in_ready combinationally.
  assign nonempty  = (count_reg != 2'd0);
  assign in_ready  = (count_reg != 2'd2);
  assign busy      = nonempty;
  assign head_sel  = sel_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  assign push = in_valid & in_ready;
  assign pop  = nonempty & out_ready[head_sel];

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_next = ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_next = ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      sel_mem[wr_ptr_reg]  <= in_sel;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign out_valid[gi] = nonempty && (head_sel == 3'(gi));
    end
  endgenerate

  assign out_data = nonempty ? head_data : '0;

endmodule

// File: tb/tb_dispatch_demux8.sv
// Scoreboard bench for dispatch_demux8: the driver queues accepted packets,
// a negedge monitor compares the presented head against the queue front.
module tb_dispatch_demux8;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = 3'd0;
  logic [31:0] in_data = 32'd0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = 8'h00;
  logic [31:0] out_data;
  logic        busy;

  pkt_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  logic [7:0]  exp_valid;
  logic [31:0] exp_data;
  int          exp_n;

  dispatch_demux8 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the queue holds exactly what the buffer should contain.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_n     = exp_q.size();
      exp_valid = (exp_n != 0) ? (8'b1 << exp_q[0].sel) : 8'h00;
      exp_data  = (exp_n != 0) ? exp_q[0].data : 32'd0;
      chk("out_valid", {24'd0, out_valid}, {24'd0, exp_valid});
      chk("out_data", out_data, exp_data);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_n != 2});
      chk("busy", {31'd0, busy}, {31'd0, exp_n != 0});
      if (exp_n != 0 && out_ready[exp_q[0].sel]) begin
        $display("pop  ch=%0d data=%h", exp_q[0].sel, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the expected buffer is updated at the commit edge.
  task automatic cyc(input logic v, input logic [2:0] s, input logic [31:0] d,
                     input logic [7:0] r, input logic f, input logic rn);
    bit acc;
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst_n     = rn;
    acc = v && (exp_q.size() != 2) && !f && rn;
    @(posedge clk);
    if (!rn || f) begin
      exp_q.delete();
      $display("%s", !rn ? "reset" : "flush");
    end else if (acc) begin
      exp_q.push_back('{sel: s, data: d});
      $display("push ch=%0d data=%h", s, d);
    end
  endtask

  task automatic idle(input int n, input logic [7:0] r);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, r, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    cyc(1'b0, 3'd0, 32'd0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 8'h00, 1'b0, 1'b0);
    mon_en = 1'b1;
    idle(2, 8'h00);

    // Routing sweep with all sinks ready
    for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), 32'hA0 + 32'(k), 8'hFF, 1'b0, 1'b1);
    idle(2, 8'hFF);

    // Backpressure to full, rejected third push, then release channel 3
    cyc(1'b1, 3'd3, 32'h11, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd5, 32'h22, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd7, 32'h33, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd7, 32'h33, 8'hF7, 1'b0, 1'b1);
    idle(2, 8'h00);
    idle(1, 8'h08);
    idle(2, 8'h00);
    idle(2, 8'hFF);

    // Head-of-line blocking: only the second packet's channel is ready
    cyc(1'b1, 3'd2, 32'h12, 8'h40, 1'b0, 1'b1);
    cyc(1'b1, 3'd6, 32'h36, 8'h40, 1'b0, 1'b1);
    idle(4, 8'h40);
    idle(3, 8'hFF);

    // Flush with two buffered plus a dropped flush-cycle push
    cyc(1'b1, 3'd1, 32'h41, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd4, 32'h44, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd0, 32'h99, 8'h00, 1'b1, 1'b1);
    idle(2, 8'hFF);
    cyc(1'b1, 3'd6, 32'h56, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd2, 32'h98, 8'h00, 1'b1, 1'b1);
    idle(2, 8'hFF);

    // Reset while full with a pop pending, then in-order refill
    cyc(1'b1, 3'd3, 32'h61, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd5, 32'h62, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd7, 32'h63, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 32'h71, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 3'd0, 32'h72, 8'h00, 1'b0, 1'b1);
    idle(1, 8'h80);
    idle(3, 8'hFF);

    // Randomized traffic with sparse flush and reset
    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom());
      cyc($urandom_range(0, 3) != 0, 3'($urandom()), $urandom(), r,
          $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
    end
    idle(4, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
